snake_move_sched: RTL and testbench
===================================

Name: snake_move_sched

Overview:
- Game-tick scheduler and direction controller for the snake head-position datapath, a 12x9 wrapping grid stepped by a 2-bit move code.
- Generates one move strobe per game tick, latches player direction requests, rejects 180-degree reversals, and sequences the idle/run/pause/over states.
- Drives the datapath's move code, move-enable and position-clear.

Parameters:
- TICK_BASE, 8'd? no: default 25000000 — clock cycles per step at speed_sel=0.
- CNT_W, default 25 — tick counter width; must hold TICK_BASE-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: begin game / acknowledge game over
- pause  in  1  one-cycle pulse: toggle run/pause
- dir_valid  in  1  direction request strobe
- dir_req  in  2  requested move code: 00 y+1, 01 y-1, 10 x+1, 11 x-1
- collision  in  1  level from collision checker, sampled every cycle
- speed_sel  in  2  step period = TICK_BASE >> speed_sel
- step  out  1  one-cycle move enable to the position datapath
- move  out  2  move code, valid when step=1; holds last issued code otherwise
- pos_clear  out  1  one-cycle clear to the position datapath
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
- step_count  out  16  steps issued this game, saturating

Behaviour:
- Reset values:
  - state=IDLE; cur_dir=10; pend_valid=0; cnt=0.
  - step=0; move=10; pos_clear=0; step_count=0.
- period = TICK_BASE >> speed_sel, recomputed every cycle.
- IDLE:
  - start → RUN next cycle with pos_clear=1 for that one cycle.
  - On the transition: cnt=0, step_count=0, cur_dir=10, pend_valid=0.
  - pause and collision are ignored.
- RUN:
  - cnt increments each cycle.
  - When cnt >= period-1: cnt←0, step←1 next cycle, move←next_dir, cur_dir←next_dir, pend_valid←0, step_count←step_count+1, saturating at FFFF.
  - next_dir = pend_dir if pend_valid, else cur_dir.
  - The >= compare makes a speed increase mid-count wrap on the next cycle; no overrun.
- Step spacing: first step occurs period cycles after entering RUN; steps are then exactly period cycles apart while speed_sel is constant.
- PAUSE:
  - pause in RUN → PAUSE.
  - pause in PAUSE → RUN.
  - cnt frozen in PAUSE; no steps issued.
- Direction requests:
  - Accepted only in RUN or PAUSE, while dir_valid=1.
  - Rejected if dir_req equals, or is the reverse of, the direction compared against. Reverse pairs are 00/01 and 10/11, i.e. differ only in bit 0.
  - Compare against cur_dir. When the request arrives in a step-commit cycle, compare against next_dir instead.
  - An accepted request sets pend_dir←dir_req, pend_valid←1, and overwrites any earlier pending request.
  - A same-cycle request with a step commit becomes pending for the following step.
- Collision:
  - collision=1 in RUN or PAUSE → OVER next cycle.
  - Collision beats a step terminal count in the same cycle: no step issued.
  - Collision beats pause in the same cycle.
- OVER:
  - step held 0; step_count held for the score display.
  - start → IDLE; pause, dir_valid and collision are ignored.
- Simultaneous events:
  - start and pause in the same cycle: only start is meaningful in IDLE/OVER; start is ignored in RUN/PAUSE.
- Mid-operation reset: all registers return to their reset values on the next edge. Any step in flight is dropped.
- All outputs are registered.

Test Plan (TICK_BASE=8, CNT_W=4):
- Reset, start pulse → pos_clear=1 one cycle, state=01; first step 8 cycles later with move=10, then every 8 cycles; step_count=1,2,3.
- In RUN with cur_dir=10: dir_req=11 → ignored, next move=10. dir_req=00 → next move=00. Then dir_req=01 → rejected, move stays 00.
- Two accepted requests before one tick (00 then 01, from cur_dir=10) → 01 accepted as not-reverse of cur_dir 10; next move=01, last request wins.
- pause after 3 counted cycles, hold 20 cycles, pause again → no steps while paused; next step exactly 5 cycles after resume.
- collision asserted on the terminal-count cycle → no step pulse, state=11 next cycle, step_count unchanged. start → state=00; second start → pos_clear, step_count=0.
- speed_sel 0→2 with cnt=5 → wrap next cycle with a step; subsequent steps every 2 cycles. Step_count saturation check: force FFFF → stays FFFF after further steps.

Source files
------------

// File: rtl/snake_move_sched.sv
// Game-tick scheduler and direction controller for the snake head-position datapath.
// Issues one move strobe per game tick, filters direction requests and sequences idle/run/pause/over.
module snake_move_sched #(
  parameter int unsigned TICK_BASE = 25000000,
  parameter int unsigned CNT_W     = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic        dir_valid_i,
  input  logic [1:0]  dir_req_i,
  input  logic        collision_i,
  input  logic [1:0]  speed_sel_i,
  output logic        step_o,
  output logic [1:0]  move_o,
  output logic        pos_clear_o,
  output logic [1:0]  state_o,
  output logic [15:0] step_count_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [1:0]       DIR_X_POS   = 2'b10;
  localparam logic [CNT_W-1:0] TICK_BASE_C = CNT_W'(TICK_BASE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [15:0]      COUNT_MAX   = 16'hFFFF;

  logic [1:0]       state_q,      state_d;
  logic [1:0]       cur_dir_q,    cur_dir_d;
  logic [1:0]       pend_dir_q,   pend_dir_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             step_q,       step_d;
  logic [1:0]       move_q,       move_d;
  logic             pos_clear_q,  pos_clear_d;
  logic [15:0]      step_count_q, step_count_d;

  logic [CNT_W-1:0] period;
  logic             in_game;
  logic             counting;
  logic             tick_hit;
  logic             commit;
  logic [1:0]       next_dir;
  logic [1:0]       ref_dir;
  logic             dir_ok;

  // Tick generation: pause and collision both suppress counting in the cycle they arrive.
  always_comb begin : tick_ctrl
    period   = TICK_BASE_C >> speed_sel_i;
    in_game  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    counting = (state_q == ST_RUN) && !collision_i && !pause_i;
    tick_hit = cnt_q >= (period - CNT_ONE);
    commit   = counting && tick_hit;
  end

  always_comb begin : dir_filter
    next_dir = pend_valid_q ? pend_dir_q : cur_dir_q;
    ref_dir  = commit ? next_dir : cur_dir_q;
    // Equal and reversed codes share bit 1, so only a change of axis is a legal turn.
    dir_ok   = in_game && dir_valid_i && (dir_req_i[1] != ref_dir[1]);
  end

  always_comb begin : next_state
    // NOTE: every _d gets a default first so no branch of the case below can infer a latch.
    state_d      = state_q;
    cur_dir_d    = cur_dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    step_d       = 1'b0;
    move_d       = move_q;
    pos_clear_d  = 1'b0;
    step_count_d = step_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_RUN;
          pos_clear_d  = 1'b1;
          cnt_d        = '0;
          step_count_d = '0;
          cur_dir_d    = DIR_X_POS;
          pend_valid_d = 1'b0;
        end
      end

      ST_RUN, ST_PAUSE: begin
        if (collision_i) begin
          state_d = ST_OVER;
        end else begin
          if (pause_i) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
          end

          if (commit) begin
            cnt_d        = '0;
            step_d       = 1'b1;
            move_d       = next_dir;
            cur_dir_d    = next_dir;
            pend_valid_d = 1'b0;
            step_count_d = (step_count_q == COUNT_MAX) ? step_count_q
                                                       : step_count_q + 16'd1;
          end else if (counting) begin
            cnt_d = cnt_q + CNT_ONE;
          end

          // Placed after the commit so a same-cycle request survives as the next pending turn.
          if (dir_ok) begin
            pend_dir_d   = dir_req_i;
            pend_valid_d = 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (start_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_dir_q    <= DIR_X_POS;
      pend_dir_q   <= 2'b00;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      step_q       <= 1'b0;
      move_q       <= DIR_X_POS;
      pos_clear_q  <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      move_q       <= move_d;
      pos_clear_q  <= pos_clear_d;
      step_count_q <= step_count_d;
    end
  end

  assign step_o       = step_q;
  assign move_o       = move_q;
  assign pos_clear_o  = pos_clear_q;
  assign state_o      = state_q;
  assign step_count_o = step_count_q;

endmodule

// File: tb/tb_snake_move_sched.sv
// Bench for snake_move_sched: directed game scenarios plus a randomized run against a
// game-level reference model that tracks elapsed tick cycles, heading and score.
module tb_snake_move_sched;

  localparam int TICK_BASE = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {M_IDLE = 2'b00, M_RUN = 2'b01, M_PAUSE = 2'b10, M_OVER = 2'b11} mode_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, pause, dir_valid, collision;
  logic [1:0]  dir_req, speed_sel;
  logic        step_o, pos_clear_o;
  logic [1:0]  move_o, state_o;
  logic [15:0] step_count_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the game as seen from the outputs.
  mode_t      m_mode;
  logic [1:0] m_cur, m_pend, m_move;
  bit         m_pend_v, m_step, m_clear;
  int         m_elapsed, m_score;

  snake_move_sched #(.TICK_BASE(TICK_BASE), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .pause_i      (pause),
    .dir_valid_i  (dir_valid),
    .dir_req_i    (dir_req),
    .collision_i  (collision),
    .speed_sel_i  (speed_sel),
    .step_o       (step_o),
    .move_o       (move_o),
    .pos_clear_o  (pos_clear_o),
    .state_o      (state_o),
    .step_count_o (step_count_o)
  );

  always #5 clk = ~clk;

  function automatic bit is_turn(input logic [1:0] req, input logic [1:0] heading);
    int req_axis, head_axis;
    req_axis  = int'(req) / 2;
    head_axis = int'(heading) / 2;
    return req_axis != head_axis;
  endfunction

  task automatic model_update();
    int  period;
    bit  counted, commit;
    logic [1:0] heading;
    m_step  = 1'b0;
    m_clear = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_cur = 2'b10; m_pend_v = 1'b0; m_elapsed = 0;
      m_move = 2'b10;  m_score = 0;
      return;
    end
    period = TICK_BASE >> speed_sel;
    case (m_mode)
      M_IDLE: if (start) begin
        m_mode = M_RUN; m_clear = 1'b1; m_elapsed = 0; m_score = 0;
        m_cur = 2'b10; m_pend_v = 1'b0;
      end
      M_OVER: if (start) m_mode = M_IDLE;
      default: begin
        if (collision) begin
          m_mode = M_OVER;
        end else begin
          counted = (m_mode == M_RUN) && !pause;
          commit  = counted && (m_elapsed + 1 >= period);
          heading = m_pend_v ? m_pend : m_cur;
          if (commit) begin
            m_step = 1'b1; m_move = heading; m_cur = heading; m_pend_v = 1'b0;
            m_elapsed = 0;
            if (m_score < 65535) m_score++;
          end else if (counted) begin
            m_elapsed++;
          end
          // m_cur already holds the heading in force after this cycle's step.
          if (dir_valid && is_turn(dir_req, m_cur)) begin
            m_pend = dir_req; m_pend_v = 1'b1;
          end
          if (pause) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    start = 1'b0; pause = 1'b0; dir_valid = 1'b0; collision = 1'b0;
  endtask

  task automatic advance(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    advance(2);
    reset = 1'b0;
    vectors++;
    if ({step_o, move_o, pos_clear_o, state_o, step_count_o} !== {1'b0, 2'b10, 1'b0, 2'b00, 16'h0}) begin
      miscompares++;
      $display("FAIL reset: got step=%b move=%b clr=%b st=%b cnt=%h, want 0 10 0 00 0000",
               step_o, move_o, pos_clear_o, state_o, step_count_o);
    end
  endtask

  task automatic test_start_steps();
    start = 1'b1;
    tick();
    vectors++;
    if (pos_clear_o !== 1'b1 || state_o !== 2'b01) begin
      miscompares++;
      $display("FAIL start: got clr=%b st=%b, want 1 01", pos_clear_o, state_o);
    end
    for (int k = 1; k <= 24; k++) begin
      tick();
      vectors++;
      if (step_o !== (k % 8 == 0) || step_count_o !== 16'(k / 8) || move_o !== 2'b10 ||
          pos_clear_o !== 1'b0) begin
        miscompares++;
        $display("FAIL first_steps k=%0d: got step=%b cnt=%0d move=%b clr=%b, want %b %0d 10 0",
                 k, step_o, step_count_o, move_o, pos_clear_o, (k % 8 == 0), k / 8);
      end
    end
  endtask

  // Each row is one 8-cycle tick: requests on cycle 1, 2 and the commit cycle 8.
  task automatic test_direction();
    bit         v1 [9] = '{1, 1, 1, 1, 1, 0, 0, 1, 0};
    logic [1:0] d1 [9] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    bit         v2 [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic [1:0] d2 [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    bit         v8 [9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
    logic [1:0] d8 [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00};
    logic [1:0] exp_move [9] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    for (int b = 0; b < 9; b++) begin
      for (int c = 1; c <= 8; c++) begin
        if (c == 1 && v1[b]) begin dir_valid = 1'b1; dir_req = d1[b]; end
        if (c == 2 && v2[b]) begin dir_valid = 1'b1; dir_req = d2[b]; end
        if (c == 8 && v8[b]) begin dir_valid = 1'b1; dir_req = d8[b]; end
        tick();
      end
      vectors++;
      if (step_o !== 1'b1 || move_o !== exp_move[b]) begin
        miscompares++;
        $display("FAIL dir_block %0d: got step=%b move=%b, want 1 %b", b, step_o, move_o, exp_move[b]);
      end
    end
    vectors++;
    if (step_count_o !== 16'd12) begin
      miscompares++;
      $display("FAIL dir_count: got %0d, want 12", step_count_o);
    end
  endtask

  task automatic test_pause();
    int steps_seen = 0;
    advance(3);
    pause = 1'b1;
    tick();
    vectors++;
    if (state_o !== 2'b10 || step_o !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_enter: got st=%b step=%b, want 10 0", state_o, step_o);
    end
    repeat (20) begin
      tick();
      if (step_o === 1'b1 || state_o !== 2'b10) steps_seen++;
    end
    vectors++;
    if (steps_seen != 0) begin
      miscompares++;
      $display("FAIL pause_hold: got %0d bad cycles, want 0", steps_seen);
    end
    pause = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (step_o !== (k == 5) || state_o !== 2'b01) begin
        miscompares++;
        $display("FAIL resume k=%0d: got step=%b st=%b, want %b 01", k, step_o, state_o, (k == 5));
      end
    end
  endtask

  task automatic test_collision();
    advance(7);
    collision = 1'b1;
    tick();
    vectors++;
    if (step_o !== 1'b0 || state_o !== 2'b11 || step_count_o !== 16'd13) begin
      miscompares++;
      $display("FAIL collide: got step=%b st=%b cnt=%0d, want 0 11 13", step_o, state_o, step_count_o);
    end
    pause = 1'b1; collision = 1'b1; dir_valid = 1'b1; dir_req = 2'b00;
    tick();
    vectors++;
    if (state_o !== 2'b11 || step_o !== 1'b0) begin
      miscompares++;
      $display("FAIL over_hold: got st=%b step=%b, want 11 0", state_o, step_o);
    end
    start = 1'b1;
    tick();
    vectors++;
    if (state_o !== 2'b00 || step_count_o !== 16'd13) begin
      miscompares++;
      $display("FAIL over_ack: got st=%b cnt=%0d, want 00 13", state_o, step_count_o);
    end
    pause = 1'b1; collision = 1'b1;
    tick();
    start = 1'b1;
    tick();
    vectors++;
    if (state_o !== 2'b01 || pos_clear_o !== 1'b1 || step_count_o !== 16'd0) begin
      miscompares++;
      $display("FAIL restart: got st=%b clr=%b cnt=%0d, want 01 1 0", state_o, pos_clear_o, step_count_o);
    end
  endtask

  task automatic test_speed_and_saturation();
    start = 1'b1;
    tick();
    vectors++;
    if (state_o !== 2'b01 || pos_clear_o !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_run: got st=%b clr=%b, want 01 0", state_o, pos_clear_o);
    end
    advance(4);
    speed_sel = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if (step_o !== (k % 2 == 1)) begin
        miscompares++;
        $display("FAIL speed_up k=%0d: got step=%b, want %b", k, step_o, (k % 2 == 1));
      end
    end
    speed_sel = 2'd3;
    for (int i = 0; i < 70000 && step_count_o !== 16'hFFFF; i++) tick();
    vectors++;
    if (step_count_o !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_reach: got %h, want ffff", step_count_o);
    end
    advance(3);
    vectors++;
    if (step_count_o !== 16'hFFFF || step_o !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_hold: got cnt=%h step=%b, want ffff 1", step_count_o, step_o);
    end
    speed_sel = 2'd0;
  endtask

  task automatic test_random();
    int bad = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 7) == 0);
      pause     = ($urandom_range(0, 15) == 0);
      dir_valid = ($urandom_range(0, 3) == 0);
      dir_req   = 2'($urandom_range(0, 3));
      collision = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 49) == 0) speed_sel = 2'($urandom_range(0, 3));
      tick();
      vectors++;
      if ({step_o, move_o, pos_clear_o, state_o, step_count_o} !==
          {m_step, m_move, m_clear, 2'(m_mode), 16'(m_score)}) begin
        miscompares++;
        if (bad++ < 10)
          $display("FAIL random cyc %0d: got step=%b move=%b clr=%b st=%b cnt=%0d, want %b %b %b %b %0d",
                   c, step_o, move_o, pos_clear_o, state_o, step_count_o,
                   m_step, m_move, m_clear, 2'(m_mode), m_score);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; dir_valid = 1'b0; collision = 1'b0;
    dir_req = 2'b00; speed_sel = 2'd0;
    test_reset();
    test_start_steps();
    test_direction();
    test_pause();
    test_collision();
    test_speed_and_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
